// File: rtl/muldiv_unit_if.sv
// Handshake bundle between the EX stage and the iterative multiply/divide unit.
// The pipeline side is the master; the unit itself is the slave.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [5:0]      alu_control;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, alu_control, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, alu_control, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// magnitudes, one bit per cycle, with a single sign-fix cycle and a divide fast path.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_unit_if.slave bus
);

  localparam logic [5:0] OP_MUL    = 6'b000110;
  localparam logic [5:0] OP_MULH   = 6'b000111;
  localparam logic [5:0] OP_MULHU  = 6'b001000;
  localparam logic [5:0] OP_MULHSU = 6'b001001;
  localparam logic [5:0] OP_DIV    = 6'b001010;
  localparam logic [5:0] OP_DIVU   = 6'b001011;
  localparam logic [5:0] OP_REM    = 6'b001100;
  localparam logic [5:0] OP_REMU   = 6'b001101;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        op_q, op_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q, acc_d;      // {partial/remainder, multiplier/quotient}
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Decode of the op being offered.
  logic [5:0]      code;
  logic            valid_code, accept, in_is_div, in_sgn_a, in_sgn_b;
  logic            a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  assign code       = bus.alu_control;
  assign valid_code = (code >= OP_MUL) && (code <= OP_REMU);
  assign accept     = bus.in_valid && (state_q == IDLE) && valid_code;
  assign in_is_div  = code inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign in_sgn_a   = code inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign in_sgn_b   = code inside {OP_MULH, OP_DIV, OP_REM};
  assign a_neg      = in_sgn_a && bus.operand_a[XLEN-1];
  assign b_neg      = in_sgn_b && bus.operand_b[XLEN-1];
  assign a_mag      = a_neg ? -bus.operand_a : bus.operand_a;
  assign b_mag      = b_neg ? -bus.operand_b : bus.operand_b;
  assign div_zero   = in_is_div && (bus.operand_b == '0);
  assign div_ovf    = (code inside {OP_DIV, OP_REM}) &&
                      (bus.operand_a == INT_MIN) && (bus.operand_b == '1);

  always_comb begin
    fast_res = '0;
    if (div_zero)
      fast_res = (code inside {OP_DIV, OP_DIVU}) ? '1 : bus.operand_a;
    else if (div_ovf)
      fast_res = (code == OP_DIV) ? INT_MIN : '0;
  end

  // One iteration of each algorithm.
  logic            op_is_div;
  logic [XLEN:0]   mul_sum, rem_sh, rem_diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod;

  assign op_is_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign rem_sh    = acc_q[2*XLEN-1:XLEN-1];
  assign rem_diff  = rem_sh - {1'b0, opnd_q};
  assign div_next  = rem_diff[XLEN] ? {rem_sh[XLEN-1:0],   acc_q[XLEN-2:0], 1'b0}
                                    : {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign prod      = neg_q ? -acc_q : acc_q;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          op_d   = code;
          cnt_d  = '0;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (div_zero || div_ovf) begin
            result_d = fast_res;
            state_d  = DONE;
          end else begin
            opnd_d  = in_is_div ? b_mag : a_mag;
            acc_d   = {{XLEN{1'b0}}, (in_is_div ? a_mag : b_mag)};
            state_d = CALC;
          end
        end
        CALC: begin
          acc_d = op_is_div ? div_next : mul_next;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        FIX: begin
          unique case (op_q)
            OP_MUL:          result_d = acc_q[XLEN-1:0];
            OP_DIV, OP_DIVU: result_d = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
            OP_REM, OP_REMU: result_d = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
            default:         result_d = prod[2*XLEN-1:XLEN];
          endcase
          state_d = DONE;
        end
        DONE: if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against an arithmetic reference model:
// results, latency, backpressure, flush and mid-operation reset.
module tb_muldiv_unit;
  localparam int XLEN = 32;
  localparam logic [5:0] MUL = 6'h06, MULH = 6'h07, MULHU = 6'h08, MULHSU = 6'h09;
  localparam logic [5:0] DIV = 6'h0A, DIVU = 6'h0B, REM = 6'h0C, REMU = 6'h0D;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();
  muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_fast(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
    bit d = (code == DIV) || (code == DIVU) || (code == REM) || (code == REMU);
    bit s = (code == DIV) || (code == REM);
    return d && (b == 0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] model(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    case (code)
      MUL:    begin p = sa * sb; return p[31:0];  end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      REM:    begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      REMU:   begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
      default: return 32'h0;
    endcase
  endfunction

  // Offer one op, wait (bounded) for out_valid, then consume the result.
  task automatic run_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    bus.in_valid = 1'b1; bus.alu_control = code; bus.operand_a = a; bus.operand_b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  typedef struct packed {
    logic [5:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [7:0]  lat;
  } vec_t;

  vec_t dir [12] = '{
    '{MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 8'd34},
    '{MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 8'd34},
    '{MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd34},
    '{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'd34},
    '{DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 8'd34},
    '{REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 8'd34},
    '{DIVU,   32'd100,        32'd7,         32'd14,        8'd34},
    '{REMU,   32'd100,        32'd7,         32'd2,         8'd34},
    '{DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 8'd1},
    '{REMU,   32'd5,          32'd0,         32'd5,         8'd1},
    '{DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 8'd1},
    '{REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         8'd1}
  };

  initial begin
    logic [31:0] res, a, b, r0;
    logic [5:0]  code;
    int lat, seen;

    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.alu_control = '0;
    bus.operand_a = '0; bus.operand_b = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_in_ready",  32'(bus.in_ready),  32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_busy",      32'(bus.busy),      32'd0);
    check("reset_result",    bus.result,         32'd0);

    foreach (dir[i]) begin
      run_op(dir[i].code, dir[i].a, dir[i].b, res, lat);
      check($sformatf("dir%0d_result", i), res, dir[i].exp);
      check($sformatf("dir%0d_latency", i), 32'(lat), 32'(dir[i].lat));
    end

    // Codes outside the RV32M range must be ignored.
    bus.in_valid = 1'b1; bus.alu_control = 6'h0E; bus.operand_a = 32'd3; bus.operand_b = 32'd4;
    @(posedge clk); #1;
    check("bad_code_hi_busy", 32'(bus.busy), 32'd0);
    bus.alu_control = 6'h05;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bad_code_lo_busy", 32'(bus.busy), 32'd0);
    check("bad_code_out_valid", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 40; i++) begin
      code = 6'(6 + $urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = 32'(-$urandom_range(1, 50));
        default: a = $urandom();
      endcase
      case ($urandom_range(0, 6))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom();
      endcase
      run_op(code, a, b, res, lat);
      check($sformatf("rnd%0d_op%0h_result", i, code), res, model(code, a, b));
      check($sformatf("rnd%0d_op%0h_latency", i, code), 32'(lat), is_fast(code, a, b) ? 32'd1 : 32'd34);
    end

    // Backpressure: result held stable and nothing accepted while DONE waits.
    a = $urandom(); b = $urandom();
    bus.in_valid = 1'b1; bus.alu_control = MULHU; bus.operand_a = a; bus.operand_b = b;
    @(posedge clk); #1;
    bus.operand_a = 32'd9; bus.operand_b = 32'd9;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    check("bp_latency", 32'(lat), 32'd34);
    r0 = bus.result;
    check("bp_result", r0, model(MULHU, a, b));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_stable%0d", i), bus.result, r0);
      check($sformatf("bp_in_ready%0d", i), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_in_ready",  32'(bus.in_ready),  32'd1);

    // Flush in CALC cycle 10.
    bus.in_valid = 1'b1; bus.alu_control = DIVU; bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_in_ready",  32'(bus.in_ready),  32'd1);
    check("flush_busy",      32'(bus.busy),      32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    check("flush_no_out_valid", 32'(seen), 32'd0);

    // Flush together with out_ready in DONE wins.
    bus.in_valid = 1'b1; bus.alu_control = DIVU; bus.operand_a = 32'd8; bus.operand_b = 32'd0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("fdone_out_valid_pre", 32'(bus.out_valid), 32'd1);
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    check("fdone_out_valid", 32'(bus.out_valid), 32'd0);
    check("fdone_in_ready",  32'(bus.in_ready),  32'd1);

    run_op(DIV, 32'hFFFF_FC18, 32'd7, res, lat);
    check("post_flush_result",  res, model(DIV, 32'hFFFF_FC18, 32'd7));
    check("post_flush_latency", 32'(lat), 32'd34);

    // Reset in the middle of CALC.
    bus.in_valid = 1'b1; bus.alu_control = MUL; bus.operand_a = 32'd123; bus.operand_b = 32'd456;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_calc_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_calc_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_calc_busy",      32'(bus.busy),      32'd0);
    check("rst_calc_result",    bus.result,         32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    check("rst_calc_no_out_valid", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
